// File: rtl/hazard_unit_mc.sv
// Hazard unit for the 5-stage MIPS pipeline: D/E forwarding selects, load-use and
// branch-compare stalls, a mult/div occupancy scoreboard and a saturating stall counter.
module hazard_unit_mc #(
    parameter int AW     = 5,
    parameter int MD_LAT = 8,
    parameter int SCW    = 16
) (
    input  logic           clk,
    input  logic           reset,
    input  logic [AW-1:0]  rsD,
    input  logic [AW-1:0]  rtD,
    input  logic [AW-1:0]  rsE,
    input  logic [AW-1:0]  rtE,
    input  logic [AW-1:0]  writeregE,
    input  logic [AW-1:0]  writeregM,
    input  logic [AW-1:0]  writeregW,
    input  logic           regwriteE,
    input  logic           regwriteM,
    input  logic           regwriteW,
    input  logic           memtoregE,
    input  logic           memtoregM,
    input  logic           branchD,
    input  logic           mdstartD,
    input  logic           mdreadD,
    input  logic           mdstartE,
    output logic           forwardaD,
    output logic           forwardbD,
    output logic [1:0]     forwardaE,
    output logic [1:0]     forwardbE,
    output logic           stallF,
    output logic           stallD,
    output logic           flushE,
    output logic           mdbusy,
    output logic [SCW-1:0] stallcnt
);

    localparam int CW = (MD_LAT < 1) ? 1 : $clog2(MD_LAT + 1);
    localparam logic [CW-1:0] MD_LOAD = CW'(MD_LAT);

    localparam logic [1:0] FWD_RF  = 2'b00;
    localparam logic [1:0] FWD_W   = 2'b01;
    localparam logic [1:0] FWD_M   = 2'b10;

    // Register 0 is hard-wired zero, so it never matches a destination.
    function automatic logic reg_match(input logic [AW-1:0] src, input logic [AW-1:0] dst);
        return (src != '0) && (src == dst);
    endfunction

    function automatic logic [SCW-1:0] sat_inc(input logic [SCW-1:0] v);
        return (v == '1) ? v : v + SCW'(1);
    endfunction

    function automatic logic [1:0] fwd_sel_e(input logic [AW-1:0] src,
                                             input logic [AW-1:0] dm, input logic wm,
                                             input logic [AW-1:0] dw, input logic ww);
        if (wm && reg_match(src, dm))
            return FWD_M;
        else if (ww && reg_match(src, dw))
            return FWD_W;
        else
            return FWD_RF;
    endfunction

    logic [CW-1:0]  r_mdcnt;
    logic [SCW-1:0] r_stallcnt;

    logic w_rsD_matchE, w_rtD_matchE;
    logic w_rsD_matchM, w_rtD_matchM;
    logic w_lwstall, w_brstall, w_mdstall;
    logic w_stall;
    logic w_mdbusy;

    // Forwarding selects are purely combinational and ignore reset.
    always_comb begin
        forwardaD = regwriteM && reg_match(rsD, writeregM);
        forwardbD = regwriteM && reg_match(rtD, writeregM);
        forwardaE = fwd_sel_e(rsE, writeregM, regwriteM, writeregW, regwriteW);
        forwardbE = fwd_sel_e(rtE, writeregM, regwriteM, writeregW, regwriteW);
    end

    always_comb begin
        w_rsD_matchE = reg_match(rsD, writeregE);
        w_rtD_matchE = reg_match(rtD, writeregE);
        w_rsD_matchM = reg_match(rsD, writeregM);
        w_rtD_matchM = reg_match(rtD, writeregM);
    end

    assign w_mdbusy  = (r_mdcnt != '0);

    assign w_lwstall = memtoregE && regwriteE && (w_rsD_matchE || w_rtD_matchE);
    // A branch compares in D, so it must also wait for an ALU result still in E
    // and for load data that is only available after M.
    assign w_brstall = branchD &&
                       ((regwriteE && (w_rsD_matchE || w_rtD_matchE)) ||
                        (memtoregM && (w_rsD_matchM || w_rtD_matchM)));
    assign w_mdstall = (mdreadD || mdstartD) && (w_mdbusy || mdstartE);

    assign w_stall   = !reset && (w_lwstall || w_brstall || w_mdstall);

    assign stallF    = w_stall;
    assign stallD    = w_stall;
    assign flushE    = w_stall;
    assign mdbusy    = w_mdbusy;
    assign stallcnt  = r_stallcnt;

    // Occupancy counter: a new op only loads when idle; an overlapping start is ignored.
    always_ff @(posedge clk) begin
        if (reset)
            r_mdcnt <= '0;
        else if (mdstartE && !w_mdbusy)
            r_mdcnt <= MD_LOAD;
        else if (w_mdbusy)
            r_mdcnt <= r_mdcnt - CW'(1);
    end

    always_ff @(posedge clk) begin
        if (reset)
            r_stallcnt <= '0;
        else if (w_stall)
            r_stallcnt <= sat_inc(r_stallcnt);
    end

endmodule

// File: tb/tb_hazard_unit_mc.sv
// Directed-vector bench for hazard_unit_mc; a second instance with a 3-bit stall
// counter shares the same stimulus to exercise saturation.
module tb_hazard_unit_mc;

    localparam int AW = 5;

    logic          clk = 1'b0;
    logic          reset;
    logic [AW-1:0] rsD, rtD, rsE, rtE, writeregE, writeregM, writeregW;
    logic          regwriteE, regwriteM, regwriteW, memtoregE, memtoregM;
    logic          branchD, mdstartD, mdreadD, mdstartE;

    logic          forwardaD, forwardbD, stallF, stallD, flushE, mdbusy;
    logic [1:0]    forwardaE, forwardbE;
    logic [15:0]   stallcnt;

    logic          s_forwardaD, s_forwardbD, s_stallF, s_stallD, s_flushE, s_mdbusy;
    logic [1:0]    s_forwardaE, s_forwardbE;
    logic [2:0]    s_stallcnt;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    hazard_unit_mc #(.AW(AW), .MD_LAT(8), .SCW(16)) u_dut (
        .clk(clk), .reset(reset),
        .rsD(rsD), .rtD(rtD), .rsE(rsE), .rtE(rtE),
        .writeregE(writeregE), .writeregM(writeregM), .writeregW(writeregW),
        .regwriteE(regwriteE), .regwriteM(regwriteM), .regwriteW(regwriteW),
        .memtoregE(memtoregE), .memtoregM(memtoregM),
        .branchD(branchD), .mdstartD(mdstartD), .mdreadD(mdreadD), .mdstartE(mdstartE),
        .forwardaD(forwardaD), .forwardbD(forwardbD),
        .forwardaE(forwardaE), .forwardbE(forwardbE),
        .stallF(stallF), .stallD(stallD), .flushE(flushE),
        .mdbusy(mdbusy), .stallcnt(stallcnt)
    );

    hazard_unit_mc #(.AW(AW), .MD_LAT(8), .SCW(3)) u_sat (
        .clk(clk), .reset(reset),
        .rsD(rsD), .rtD(rtD), .rsE(rsE), .rtE(rtE),
        .writeregE(writeregE), .writeregM(writeregM), .writeregW(writeregW),
        .regwriteE(regwriteE), .regwriteM(regwriteM), .regwriteW(regwriteW),
        .memtoregE(memtoregE), .memtoregM(memtoregM),
        .branchD(branchD), .mdstartD(mdstartD), .mdreadD(mdreadD), .mdstartE(mdstartE),
        .forwardaD(s_forwardaD), .forwardbD(s_forwardbD),
        .forwardaE(s_forwardaE), .forwardbE(s_forwardbE),
        .stallF(s_stallF), .stallD(s_stallD), .flushE(s_flushE),
        .mdbusy(s_mdbusy), .stallcnt(s_stallcnt)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic chk_stall(input string tag, input logic exp);
        chk({tag, ".stallF"}, {31'b0, stallF}, {31'b0, exp});
        chk({tag, ".stallD"}, {31'b0, stallD}, {31'b0, exp});
        chk({tag, ".flushE"}, {31'b0, flushE}, {31'b0, exp});
    endtask

    task automatic clear_inputs();
        rsD = '0; rtD = '0; rsE = '0; rtE = '0;
        writeregE = '0; writeregM = '0; writeregW = '0;
        regwriteE = 1'b0; regwriteM = 1'b0; regwriteW = 1'b0;
        memtoregE = 1'b0; memtoregM = 1'b0;
        branchD = 1'b0; mdstartD = 1'b0; mdreadD = 1'b0; mdstartE = 1'b0;
    endtask

    // Advance one clock; inputs change and outputs are sampled 1 time unit after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        clear_inputs();
        reset = 1'b1;
        step();
        reset = 1'b0;
        #1;
    endtask

    initial begin
        reset = 1'b1;
        clear_inputs();
        step();
        step();
        chk("rst.stallcnt", 32'(stallcnt), 0);
        chk("rst.mdbusy", {31'b0, mdbusy}, 0);
        // Load-use condition present while in reset: stall outputs forced low
        memtoregE = 1'b1; regwriteE = 1'b1; writeregE = 5'd5; rtD = 5'd5;
        #1;
        chk_stall("rst.force", 1'b0);
        step();
        chk("rst.cnt_hold", 32'(stallcnt), 0);
        do_reset();

        // Forwarding to E
        writeregM = 5'd3; regwriteM = 1'b1; writeregW = 5'd3; regwriteW = 1'b1; rsE = 5'd3;
        #1;
        chk("fwdE.M", 32'(forwardaE), 2);
        regwriteM = 1'b0;
        #1;
        chk("fwdE.W", 32'(forwardaE), 1);
        rtE = 5'd3;
        #1;
        chk("fwdE.bW", 32'(forwardbE), 1);
        rsE = 5'd0; writeregM = 5'd0; regwriteM = 1'b1;
        #1;
        chk("fwdE.r0", 32'(forwardaE), 0);
        chk_stall("fwdE.nostall", 1'b0);

        // Load-use stall
        clear_inputs();
        memtoregE = 1'b1; regwriteE = 1'b1; writeregE = 5'd5; rtD = 5'd5;
        #1;
        chk_stall("lw.stall", 1'b1);
        chk("lw.cnt0", 32'(stallcnt), 0);
        step();
        chk("lw.cnt1", 32'(stallcnt), 1);
        memtoregE = 1'b0; regwriteE = 1'b0; writeregE = 5'd0;
        memtoregM = 1'b1; regwriteM = 1'b1; writeregM = 5'd5; rtE = 5'd5;
        #1;
        chk("lw.fwdbE", 32'(forwardbE), 2);
        chk_stall("lw.release", 1'b0);
        step();
        chk("lw.cnt_hold", 32'(stallcnt), 1);

        // Branch compare stall
        clear_inputs();
        branchD = 1'b1; rsD = 5'd7; regwriteE = 1'b1; writeregE = 5'd7;
        #1;
        chk_stall("br.stallE", 1'b1);
        step();
        chk("br.cnt", 32'(stallcnt), 2);
        regwriteE = 1'b0; writeregE = 5'd0; regwriteM = 1'b1; writeregM = 5'd7;
        #1;
        chk("br.fwdaD", {31'b0, forwardaD}, 1);
        chk("br.fwdbD", {31'b0, forwardbD}, 0);
        chk_stall("br.release", 1'b0);
        memtoregM = 1'b1;
        #1;
        chk_stall("br.loadM", 1'b1);
        branchD = 1'b0;
        #1;
        chk_stall("br.nobranch", 1'b0);

        // Mult/div occupancy: issue at t with a dependent mfhi in D from t
        do_reset();
        mdstartE = 1'b1; mdreadD = 1'b1;
        #1;
        chk_stall("md.t", 1'b1);
        chk("md.busy_t", {31'b0, mdbusy}, 0);
        step();
        mdstartE = 1'b0;
        for (int k = 1; k <= 8; k++) begin
            #1;
            chk($sformatf("md.busy_t%0d", k), {31'b0, mdbusy}, 1);
            chk($sformatf("md.stall_t%0d", k), {31'b0, stallF}, 1);
            step();
        end
        chk("md.busy_t9", {31'b0, mdbusy}, 0);
        chk_stall("md.release", 1'b0);
        chk("md.cnt", 32'(stallcnt), 9);

        // Back-to-back mult/div and start without dependent D instruction
        do_reset();
        mdstartE = 1'b1;
        #1;
        chk_stall("md2.nodep", 1'b0);
        step();
        mdstartE = 1'b0; mdstartD = 1'b1;
        #1;
        chk_stall("md2.b2b", 1'b1);

        // Saturation: hold load-use for 10 cycles
        do_reset();
        memtoregE = 1'b1; regwriteE = 1'b1; writeregE = 5'd9; rsD = 5'd9;
        for (int k = 0; k < 10; k++) step();
        chk("sat.cnt3", 32'(s_stallcnt), 7);
        chk("sat.cnt16", 32'(stallcnt), 10);

        // Reset mid mult/div aborts occupancy
        do_reset();
        mdstartE = 1'b1;
        step();
        mdstartE = 1'b0;
        #1;
        chk("abort.busy_t1", {31'b0, mdbusy}, 1);
        step();
        step();
        reset = 1'b1; mdreadD = 1'b1;
        #1;
        chk_stall("abort.rst", 1'b0);
        step();
        reset = 1'b0;
        #1;
        chk("abort.busy_t4", {31'b0, mdbusy}, 0);
        chk("abort.cnt_t4", 32'(stallcnt), 0);
        chk_stall("abort.mfhi", 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/hazard_unit_mc.md
Name: hazard_unit_mc

Overview:
- Parametrised next-generation hazard unit for the 5-stage MIPS pipeline.
- Combines the D/E-stage forwarding selects with load-use stalls and branch-compare stalls.
- Adds a multicycle mult/div busy scoreboard that stalls HI/LO readers and back-to-back mult/div ops.
- Adds a saturating stall-cycle counter for performance monitoring.
- Sits beside the datapath: inputs are register numbers and control bits from D/E/M/W; outputs drive the forwarding muxes, pipeline-register enables and flushes.

Parameters:
AW, 5, register-address width (2**AW architectural registers; register 0 is hard-wired zero and never forwarded)
MD_LAT, 8, mult/div occupancy in cycles after issue into E (>=1)
SCW, 16, width of saturating stall counter

Ports:
clk  input  1  pipeline clock, all state on rising edge
reset  input  1  synchronous, active-high
rsD  input  AW  source register A of instruction in D
rtD  input  AW  source register B of instruction in D
rsE  input  AW  source register A in E
rtE  input  AW  source register B in E
writeregE  input  AW  destination register in E
writeregM  input  AW  destination register in M
writeregW  input  AW  destination register in W
regwriteE  input  1  E instruction writes the register file
regwriteM  input  1  M instruction writes the register file
regwriteW  input  1  W instruction writes the register file
memtoregE  input  1  E instruction is a load
memtoregM  input  1  M instruction is a load
branchD  input  1  D instruction is a branch compared in D
mdstartD  input  1  D instruction is mult/div
mdreadD  input  1  D instruction is mfhi/mflo
mdstartE  input  1  mult/div entering execution this cycle
forwardaD  output  1  forward ALUOutM to D compare operand A
forwardbD  output  1  forward ALUOutM to D compare operand B
forwardaE  output  2  E operand A select: 00 regfile, 01 ResultW, 10 ALUOutM
forwardbE  output  2  E operand B select, same encoding
stallF  output  1  hold PC
stallD  output  1  hold IF/ID register
flushE  output  1  clear ID/EX register (bubble)
mdbusy  output  1  mult/div unit occupied
stallcnt  output  SCW  saturating count of stalled cycles

Behaviour:
- Match rule: "X matches dest d" means X!=0 and X==d.
- Forwarding (combinational):
  - forwardaD = rsD matches writeregM & regwriteM; forwardbD likewise with rtD.
  - forwardaE = 10 if rsE matches writeregM & regwriteM; else 01 if rsE matches writeregW & regwriteW; else 00. M has priority over W. forwardbE likewise with rtE.
- lwstall = memtoregE & regwriteE & (rsD or rtD matches writeregE).
- brstall = branchD & ((regwriteE & (rsD|rtD matches writeregE)) | (memtoregM & (rsD|rtD matches writeregM))).
- mdstall = (mdreadD | mdstartD) & (mdbusy | mdstartE).
- stall = lwstall | brstall | mdstall. stallF = stallD = flushE = stall, combinational, no added latency.
- Mult/div counter mdcnt, width clog2(MD_LAT+1):
  - reset -> 0.
  - mdstartE with mdcnt==0 loads MD_LAT.
  - Otherwise, if mdcnt!=0, decrement by 1.
  - mdstartE while mdcnt!=0 is illegal, cannot occur given mdstall; counter ignores it and keeps decrementing.
  - mdbusy = (mdcnt!=0), registered-state derived.
  - Net effect: a dependent mfhi in D stalls in the issue cycle plus MD_LAT cycles.
- Stall counter: reset -> 0; +1 each cycle stall=1; saturates at 2**SCW-1, no wrap.
- Reset values: mdcnt=0, mdbusy=0, stallcnt=0. While reset is high, stall outputs are forced 0. Forwarding outputs stay purely combinational.
- Reset asserted mid mult/div aborts occupancy: mdbusy=0 from the following cycle.
- Simultaneous events: lwstall and mdstall together count as one stall cycle. A flushed E (bubble) presents regwriteE=0 and mdstartE=0 to this block.

Test Plan:
- add $3 in M, add $3 in W, rsE=3, both regwrite=1 -> forwardaE=10. Drop regwriteM -> 01. Set rsE=0 with writeregM=0 -> 00.
- lw $5 in E (memtoregE=1, regwriteE=1, writeregE=5), rtD=5 -> stallF=stallD=flushE=1 one cycle, stallcnt 0->1. Next cycle lw in M, forwardbE=10, no stall.
- beq in D with rsD=7, addi $7 in E -> brstall 1 cycle. Next cycle addi in M -> forwardaD=1, no stall.
- MD_LAT=8: mdstartE pulse at cycle t, mfhi in D from t -> stall high cycles t..t+8, mdbusy high t+1..t+8, released at t+9, stallcnt=9.
- SCW=3, hold lwstall condition 10 cycles -> stallcnt saturates at 7.
- Mult/div issued, reset pulsed at t+3 -> mdbusy=0 and stallcnt=0 at t+4; mfhi then proceeds without stall.
